// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-ported unified memory between the fetch port
// and the data port. Data wins by default; a starvation counter forces a
// fetch grant after STARVE_LIMIT consecutive data grants taken while fetch
// was waiting. A per-access timer aborts accesses the memory never acks.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no access in flight; arbitrate between if_req and d_req
// IF_BUSY | fetch access on the memory bus, waiting for mem_ack
// D_BUSY  | data access on the memory bus, waiting for mem_ack
module unified_mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              err
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, IF_BUSY, D_BUSY} state_t;

    state_t            state, stateNext;
    logic [ADDR_W-1:0] addrQ, addrNext;
    logic [DATA_W-1:0] wdataQ, wdataNext;
    logic              weQ, weNext;
    logic [SW-1:0]     starveCnt, starveNext;
    logic [TW-1:0]     timer, timerNext;
    logic              errQ, errNext;

    logic busy;
    logic fetchPri;
    logic accessDone;
    logic timeoutHit;

    assign busy       = (state != IDLE);
    assign fetchPri   = if_req && (starveCnt == STARVE_MAX);
    assign accessDone = busy && (mem_ack || (timer == TIMER_LAST));
    assign timeoutHit = busy && !mem_ack && (timer == TIMER_LAST);

    // Memory bus is driven only from the latched request, never the live inputs.
    assign mem_req   = busy;
    assign mem_we    = weQ;
    assign mem_addr  = addrQ;
    assign mem_wdata = wdataQ;
    assign err       = errQ;

    // Ready is combinational with ack so the requester can advance on the same edge.
    assign if_ready = (state == IF_BUSY) && accessDone;
    assign d_ready  = (state == D_BUSY) && accessDone;
    assign if_rdata = timeoutHit ? '0 : mem_rdata;
    assign d_rdata  = timeoutHit ? '0 : mem_rdata;

    // State and latched-request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addrQ     <= '0;
            wdataQ    <= '0;
            weQ       <= 1'b0;
            starveCnt <= '0;
            timer     <= '0;
            errQ      <= 1'b0;
        end else begin
            state     <= stateNext;
            addrQ     <= addrNext;
            wdataQ    <= wdataNext;
            weQ       <= weNext;
            starveCnt <= starveNext;
            timer     <= timerNext;
            errQ      <= errNext;
        end
    end

    // Arbitration, access completion and timeout.
    always_comb begin
        stateNext  = state;
        addrNext   = addrQ;
        wdataNext  = wdataQ;
        weNext     = weQ;
        starveNext = starveCnt;
        timerNext  = timer;
        errNext    = errQ;

        case (state)
            IDLE: begin
                timerNext = '0;
                if (mem_ack) begin
                    errNext = 1'b1;
                end
                if (d_req && !fetchPri) begin
                    stateNext = D_BUSY;
                    addrNext  = d_addr;
                    weNext    = d_we;
                    wdataNext = d_wdata;
                    if (if_req) begin
                        starveNext = (starveCnt == STARVE_MAX) ? STARVE_MAX : starveCnt + SW'(1);
                    end else begin
                        starveNext = '0;
                    end
                end else if (if_req) begin
                    stateNext  = IF_BUSY;
                    addrNext   = if_addr;
                    weNext     = 1'b0;
                    starveNext = '0;
                end
            end
            IF_BUSY, D_BUSY: begin
                if (timeoutHit) begin
                    errNext = 1'b1;
                end
                if (accessDone) begin
                    stateNext = IDLE;
                    timerNext = '0;
                end else begin
                    timerNext = timer + TW'(1);
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
Shares one single-ported unified instruction/data memory between the pipelined core's fetch port (PCF) and its memory-stage data port (ALUResult/WriteData/MemWrite).
- Grants one requester at a time through a small FSM and drives the shared memory with a req/ack handshake.
- Returns per-port ready strobes that the core's hazard unit uses to stall IF or MEM.
- Data accesses win by default, since they belong to the older instruction. A starvation counter guarantees fetch forward progress.

Parameters:
ADDR_W, 32, width of all address buses
DATA_W, 32, width of all data buses
STARVE_LIMIT, 4, consecutive data grants allowed while fetch is waiting; at the limit, fetch wins the next arbitration
TIMEOUT, 16, cycles a granted access may wait for mem_ack before it is aborted

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous assert, active-low
if_req  in  1  fetch request; held with if_addr until if_ready
if_addr  in  ADDR_W  fetch address
if_rdata  out  DATA_W  fetched word; valid only while if_ready=1
if_ready  out  1  fetch complete this cycle
d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_ready
d_we  in  1  1=store, 0=load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_rdata  out  DATA_W  load data; valid only while d_ready=1 and the access is a load
d_ready  out  1  data access complete this cycle
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid with mem_ack
mem_ack  in  1  memory completes the access this cycle
err  out  1  sticky error flag; cleared only by reset

Behaviour:
- Reset (rst_n=0, at any time, including mid-access):
  - state=IDLE immediately; mem_req, mem_we, if_ready, d_ready, err = 0.
  - Latched mem_addr and mem_wdata = 0; starve_cnt=0; timer=0.
  - No pending access survives reset.
- FSM states: IDLE, IF_BUSY, D_BUSY.
- IDLE, arbitration (evaluated every cycle):
  - fetch_pri = if_req & (starve_cnt==STARVE_LIMIT).
  - If d_req & ~fetch_pri: go to D_BUSY. Latch d_addr, d_we, d_wdata. If if_req=1, starve_cnt++ (saturating at STARVE_LIMIT); otherwise starve_cnt=0.
  - Else if if_req: go to IF_BUSY. Latch if_addr, set mem_we=0, starve_cnt=0.
  - Else: stay in IDLE.
- IF_BUSY / D_BUSY:
  - mem_req=1 and mem_addr/mem_we/mem_wdata are driven from the latched registers only. They stay stable until ack; live requester inputs are ignored.
  - On mem_ack=1, same cycle and combinationally:
    - if_ready (IF_BUSY) or d_ready (D_BUSY) = 1.
    - if_rdata / d_rdata = mem_rdata.
    - Next state is IDLE; timer=0.
  - Outside their ready cycles, if_rdata and d_rdata also pass mem_rdata through and are don't-care.
- Latency: request seen in IDLE at cycle 0 → mem_req=1 at cycle 1 → ready in the same cycle as mem_ack (at the earliest, cycle 1).
  - Each completed access is followed by one IDLE cycle, so single-port throughput is at most one access every 2 cycles.
- Ready is combinational with ack. This lets the requester advance its address on the same edge, so a held-high req in the following IDLE cycle is always a new transaction.
- mem_ack while in IDLE: ignored (no ready pulse); err is set.
- Timeout:
  - timer counts cycles spent in a BUSY state without mem_ack.
  - When timer reaches TIMEOUT-1 without ack: go to IDLE, set err=1, pulse the owning port's ready with rdata=0. The core is never deadlocked.
- Simultaneous if_req & d_req in IDLE: data wins unless fetch_pri=1.
- Stores: d_ready pulses on ack; d_rdata is don't-care.
- A requester dropping req before its ready does not cancel an in-flight grant. The access completes and ready still pulses.

Test Plan:
1. Reset mid-access: grant fetch of 0x00000010 and hold mem_ack=0 → assert rst_n=0 → mem_req=0 in the same cycle; after release, state=IDLE and no ready pulse occurs.
2. Single fetch: if_req=1, if_addr=0x00000008; memory acks on the first mem_req cycle with 0xE2811001 → mem_req=1 at cycle 1, mem_addr=0x8, if_ready=1 and if_rdata=0xE2811001 at cycle 1; mem_req=0 at cycle 2.
3. Contention: if_req and d_req both held high; load at 0x20 and store of 0xDEADBEEF at 0x24, with zero-wait ack → data served first (mem_we=0 @0x20), then the store (mem_we=1, mem_wdata=0xDEADBEEF), with fetch waiting each time.
4. Starvation: d_req held high for 10 transactions with if_req high, STARVE_LIMIT=4 → exactly 4 data grants, then 1 fetch grant, then 4 data grants, and so on.
5. Wait states: mem_ack delayed 3 cycles on load 0x40 → mem_addr/mem_we are stable for all 4 cycles even when d_addr changes to 0x44 mid-access; d_ready pulses once.
6. Faults: mem_ack=1 in IDLE → err=1, no ready. Separately, a fetch with no ack for 16 cycles → if_ready=1, if_rdata=0, err=1, state returns to IDLE.
